fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001 Parameter DEPTH, default 4, queue entries; power of two, >=2.
- REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
- REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
- REQ-004 i_reset  in  1  synchronous, active-high reset.
- REQ-005 o_memReq  out  1  instruction-memory fetch request.
- REQ-006 o_memAddr  out  32  fetch address, word aligned.
- REQ-007 i_memGnt  in  1  request accepted when o_memReq && i_memGnt.
- REQ-008 i_memRvalid  in  1  response valid: in order, >=1 cycle after grant, never back-pressured.
- REQ-009 i_memRdata  in  32  response instruction word.
- REQ-010 o_valid  out  1  queue head valid toward decode.
- REQ-011 o_inst  out  32  head instruction.
- REQ-012 o_pc  out  32  head instruction address.
- REQ-013 i_ready  in  1  decode consumes head when o_valid && i_ready.
- REQ-014 i_redirect  in  1  one-cycle flush/redirect from branch resolution.
- REQ-015 i_redirectPC  in  32  new fetch address; bits [1:0] ignored (treated as 0).

Function
- REQ-016 Fetch PC register holds the next request address; it SHALL advance by 4 on each grant.
- REQ-017 o_memReq SHALL be 1 only when (occupancy + outstanding) < DEPTH, i_redirect == 0 and i_reset == 0.
- REQ-018 Outstanding counter (log2(DEPTH)+1 bits): +1 on grant, -1 on i_memRvalid; both in one cycle leave it unchanged.
- REQ-019 Each non-discarded response SHALL be written to the queue tail with its PC (tracked in a FIFO of granted addresses or an equivalent response-PC counter).
- REQ-020 Default latency: response at cycle N appears on o_valid/o_inst at cycle N+1.
- REQ-021 Queue SHALL be a circular buffer with read/write pointers wrapping at DEPTH; a push and pop in the same cycle leave occupancy unchanged, including when the queue is full.
- REQ-022 The credit rule (REQ-017) SHALL make overflow impossible; a response arriving while full is a protocol violation and need not be handled.
- REQ-023 o_inst/o_pc SHALL hold stable while o_valid && !i_ready.
- REQ-024 On i_redirect: clear the queue (o_valid = 0 next cycle); set fetch PC to {i_redirectPC[31:2],2'b00}; set the discard counter to outstanding-after-this-cycle; a head pop in the same cycle is ignored.
- REQ-025 While the discard counter is nonzero, each i_memRvalid SHALL decrement it and drop the data.
- REQ-026 A response arriving in the redirect cycle itself SHALL be dropped; it is not included in the discard counter.
- REQ-027 First request after redirect SHALL issue in cycle R+1 at the new PC.
- REQ-028 A redirect during a non-zero discard count SHALL reload the discard counter with the total outstanding count.

Reset
- REQ-029 While i_reset is high: o_memReq = 0, o_valid = 0, queue empty, outstanding = 0, discard = 0, fetch PC = RESET_PC, o_inst = 0, o_pc = 0.
- REQ-030 Reset asserted mid-operation SHALL drop all queued and in-flight instructions; the bench SHALL not return responses for pre-reset grants after reset.
- REQ-031 First request SHALL issue in the first cycle after reset deasserts, with o_memAddr = RESET_PC.

Configuration
- REQ-032 Macro FETCH_QUEUE_BYPASS_EN: when defined, a response arriving while the queue is empty (and not discarded, no redirect) SHALL drive o_valid/o_inst/o_pc combinationally in the same cycle; it is enqueued only if not consumed that cycle.
- REQ-033 When FETCH_QUEUE_BYPASS_EN is undefined, all outputs toward decode come from registers and REQ-020 latency applies.

Verification
- REQ-034 Reset release, i_memGnt = 1, 1-cycle memory, i_ready = 1 -> addresses 0x0, 0x4, 0x8 requested on consecutive cycles; o_pc follows 0x0, 0x4, 0x8 with data matching.
- REQ-035 i_ready = 0, DEPTH = 4 -> after 4 responses, o_memReq = 0 and o_pc stays 0x0; one i_ready pulse -> o_pc = 0x4 and exactly one new request issued.
- REQ-036 3 requests outstanding (3-cycle memory), i_redirect with i_redirectPC = 0x103 -> the 3 stale responses are dropped; next o_memAddr = 0x100; first o_valid shows o_pc = 0x100.
- REQ-037 i_redirect and i_memRvalid in the same cycle, with a head pop -> that data never appears on o_inst; o_valid = 0 next cycle.
- REQ-038 i_reset asserted for 1 cycle with a full queue -> o_valid = 0 next cycle; following request address = RESET_PC.
- REQ-039 FETCH_QUEUE_BYPASS_EN defined, empty queue, response 0xDEADBEEF -> o_valid = 1 and o_inst = 0xDEADBEEF in the response cycle; undefined -> one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with credit-limited fetch, redirect discard, optional empty-queue bypass (FETCH_QUEUE_BYPASS_EN)
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memGnt,
  input  logic        i_memRvalid,
  input  logic [31:0] i_memRdata,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPC
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [CW-1:0] count, outstanding, discard, out_next;
  logic [31:0] fetch_pc, rsp_pc;
  logic gnt, accept, bypass, live, push, pop;
  assign o_memReq = !i_reset && !i_redirect && (count + outstanding < CW'(DEPTH));
  assign o_memAddr = fetch_pc;
  assign gnt = o_memReq && i_memGnt;
  assign accept = i_memRvalid && !i_redirect && discard == '0;
  assign out_next = outstanding + CW'(gnt) - CW'(i_memRvalid);
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = accept && !i_reset && count == '0;
`else
  assign bypass = 1'b0;
`endif
  assign live = !i_reset && count != '0;
  assign o_valid = bypass || live;
  assign o_inst = bypass ? i_memRdata : live ? inst_q[rptr] : '0;
  assign o_pc = bypass ? rsp_pc : live ? pc_q[rptr] : '0;
  assign push = accept && !(bypass && i_ready);
  assign pop = live && i_ready && !i_redirect;
  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_q[wptr] <= i_memRdata;
      pc_q[wptr] <= rsp_pc;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      rptr <= '0;
      wptr <= '0;
      count <= '0;
      outstanding <= '0;
      discard <= '0;
    end else begin
      outstanding <= out_next;
      if (i_redirect) begin
        fetch_pc <= {i_redirectPC[31:2], 2'b00};
        rsp_pc <= {i_redirectPC[31:2], 2'b00};
        rptr <= '0;
        wptr <= '0;
        count <= '0;
        discard <= out_next;
      end else begin
        if (gnt) fetch_pc <= fetch_pc + 32'd4;
        if (discard != '0 && i_memRvalid) discard <= discard - 1'b1;
        if (accept) rsp_pc <= rsp_pc + 32'd4;
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized check of fetch_queue against a queue-level reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0200;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [31:0] addr;
    int due;
    bit stale;
  } req_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0, valid, ready = 1'b0, redirect = 1'b0;
  logic [31:0] mem_addr, inst, pc;
  logic [31:0] mem_rdata = '0;
  logic [31:0] redirect_pc = '0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  req_t inflight[$];
  logic [31:0] mq[$];
  logic [31:0] mpc = RPC;
  always #5 clk = ~clk;
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .o_memReq(mem_req),
    .o_memAddr(mem_addr),
    .i_memGnt(mem_gnt),
    .i_memRvalid(mem_rvalid),
    .i_memRdata(mem_rdata),
    .o_valid(valid),
    .o_inst(inst),
    .o_pc(pc),
    .i_ready(ready),
    .i_redirect(redirect),
    .i_redirectPC(redirect_pc)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input bit r, input int pg, input int pr, input int pd, input int lmin, input int lmax);
    bit resp, take, eq, hv, byp;
    logic [31:0] head, raddr;
    req_t e;
    @(negedge clk);
    resp = !r && inflight.size() > 0 && inflight[0].due <= cyc;
    raddr = resp ? inflight[0].addr : 32'h0;
    rst = r;
    mem_gnt = $urandom_range(99) < pg;
    ready = $urandom_range(99) < pr;
    redirect = !r && $urandom_range(99) < pd;
    redirect_pc = $urandom_range(65535);
    mem_rvalid = resp;
    mem_rdata = resp ? word(raddr) : $urandom;
    #1;
    if (r) begin
      check("req_rst", 32'(mem_req), 32'd0);
      check("valid_rst", 32'(valid), 32'd0);
      check("inst_rst", inst, 32'd0);
      check("pc_rst", pc, 32'd0);
      mq.delete();
      inflight.delete();
      mpc = RPC;
    end else begin
      take = resp && !redirect && !inflight[0].stale;
      eq = !redirect && (mq.size() + inflight.size()) < DEPTH;
      if (resp) e = inflight.pop_front();
      byp = BYP && take && mq.size() == 0;
      hv = mq.size() > 0 || byp;
      head = mq.size() > 0 ? mq[0] : raddr;
      check("mem_req", 32'(mem_req), 32'(eq));
      check("mem_addr", mem_addr, mpc);
      check("valid", 32'(valid), 32'(hv));
      if (hv) begin
        check("pc", pc, head);
        check("inst", inst, word(head));
      end
      if (redirect) begin
        mq.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        mpc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (hv && ready && !byp) void'(mq.pop_front());
        if (take && !(byp && ready)) mq.push_back(raddr);
      end
      if (eq && mem_gnt) begin
        e.addr = mpc;
        e.due = cyc + int'($urandom_range(lmax, lmin));
        e.stale = 1'b0;
        inflight.push_back(e);
        mpc += 32'd4;
      end
    end
    cyc++;
  endtask
  initial begin
    repeat (3) step(1'b1, 0, 0, 0, 1, 1);
    repeat (20) step(1'b0, 100, 100, 0, 1, 1);
    repeat (20) step(1'b0, 100, 0, 0, 1, 1);
    step(1'b0, 100, 100, 0, 1, 1);
    repeat (10) step(1'b0, 100, 0, 0, 1, 1);
    repeat (8) step(1'b0, 100, 100, 0, 3, 3);
    step(1'b0, 100, 100, 100, 3, 3);
    repeat (12) step(1'b0, 100, 100, 0, 3, 3);
    repeat (10) step(1'b0, 100, 0, 0, 1, 2);
    step(1'b1, 100, 0, 0, 1, 1);
    repeat (6) step(1'b0, 100, 100, 0, 1, 1);
    repeat (3000) step($urandom_range(199) == 0, 70, 60, 5, 1, 4);
    repeat (1000) step(1'b0, 90, 30, 10, 2, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
